word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
- Parametrised parallel-to-serial converter. Accepts a vector of NUM_WORDS words, each WIDTH bits, and emits them one word per transfer on a streaming output.
- Successor to the fixed 4x16 counter-driven serializer. Adds:
  - valid/ready handshakes on both sides
  - a per-transaction length
  - selectable word order
  - a last-word marker
  - back-to-back operation with no bubble
- Sits between wide datapath stages and narrow links or serial lanes.

Parameters:
- WIDTH, 16, bits per word.
- NUM_WORDS, 4, words per input vector; must be ≥2.
- REVERSE, 0, word order. 0: word 0 first, ascending. 1: word len-1 first, descending.
- CW, $clog2(NUM_WORDS+1), width of the length field (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  NUM_WORDS*WIDTH  packed vector; word k = in_data[k*WIDTH +: WIDTH].
- in_len  input  CW  number of words to send, 1..NUM_WORDS.
- in_valid  input  1  in_data and in_len are valid.
- in_ready  output  1  block can accept a vector this cycle.
- out_data  output  WIDTH  current output word.
- out_valid  output  1  out_data is valid.
- out_last  output  1  current word is the final word of the transaction.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- State: IDLE / SEND.
  - Storage: buffer of NUM_WORDS x WIDTH registers.
  - Word index idx, $clog2(NUM_WORDS) bits.
  - Latched length len.
  - Step counter cnt, CW bits.
- Reset (async, while rst=1): state=IDLE, idx=0, cnt=0, len=0, buffer contents don't-care. Outputs: out_valid=0, out_last=0, out_data=0, in_ready=1.
- Transfer definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- in_ready is combinational: (state==IDLE) | (out_fire & out_last). Must not depend on in_valid.
- On in_fire:
  - Capture all words and the effective length L.
  - L = in_len, except in_len==0 or in_len>NUM_WORDS gives L = NUM_WORDS.
  - Next state = SEND, cnt=0.
  - idx = 0 if REVERSE=0, else L-1.
- Latency: first word is presented with out_valid=1 on the cycle after in_fire. There is no combinational in→out path.
- In SEND:
  - out_valid=1.
  - out_data = buffer[idx].
  - out_last = (cnt==len-1).
- On out_fire with out_last=0: cnt+1; idx+1 (REVERSE=0) or idx-1 (REVERSE=1).
- On out_fire with out_last=1:
  - If in_fire in the same cycle: reload per the capture rule and stay in SEND. The next cycle shows word 0 (or L-1) of the new vector, with no idle cycle.
  - Otherwise: go to IDLE, out_valid=0.
- Stall (out_valid=1, out_ready=0): out_data, out_last, idx and cnt hold stable for any number of cycles. in_ready=0.
- L=1: the single word is presented with out_last=1 on the first cycle.
- Full throughput: with out_ready held high and in_valid held high, the output carries one word every cycle indefinitely.
- out_data is 0 whenever out_valid=0 (IDLE).
- Reset asserted mid-transaction: the transaction is aborted immediately. After rst deasserts, no partial words are emitted; the block is in IDLE with in_ready=1.
- in_data/in_len changes while in_ready=0 are ignored.

Test Plan:
- Basic order:
  - Stimulus: WIDTH=16, NUM_WORDS=4, REVERSE=0. in_data words {0x1111,0x2222,0x3333,0x4444} (word0..3), in_len=4, out_ready=1.
  - Response: out_data 0x1111,0x2222,0x3333,0x4444 on cycles 1..4 after accept; out_last=1 only with 0x4444; in_ready=1 on cycle 4.
- Reverse and short length:
  - Stimulus: REVERSE=1, same data, in_len=3.
  - Response: 0x3333,0x2222,0x1111; out_last on 0x1111; 0x4444 is never emitted.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles after the 2nd word appears.
  - Response: out_data=0x2222 and out_last=0 stable throughout; in_ready=0; sequence resumes intact when out_ready rises.
- Back-to-back:
  - Stimulus: two vectors, A={0xA0..0xA3} then B={0xB0..0xB3}, in_valid held high, out_ready=1.
  - Response: 8 consecutive words A0..A3,B0..B3 with no gap; out_last on A3 and on B3.
- Length edge cases:
  - Stimulus 1: in_len=0. Response: 4 words sent.
  - Stimulus 2: in_len=1 with word0=0xBEEF. Response: single beat 0xBEEF with out_last=1, then IDLE.
- Mid-operation reset:
  - Stimulus: assert rst asynchronously (between clock edges) after the 2nd output word.
  - Response: out_valid=0, out_data=0, in_ready=1 immediately; no further words after release; a new vector is then serialized correctly from word 0.

Source files
------------

// File: rtl/word_serializer.sv
// Parallel-to-serial word converter with valid/ready on both sides, per-vector
// length, selectable word order and a last-word marker; reloads back-to-back.
module word_serializer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned REVERSE   = 0,
  localparam int unsigned CW       = $clog2(NUM_WORDS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WORDS*WIDTH-1:0] in_data,
  input  logic [CW-1:0]              in_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready
);

  localparam int unsigned IW = $clog2(NUM_WORDS);
  localparam logic [CW-1:0] LEN_ONE = CW'(1);
  localparam logic [CW-1:0] LEN_MAX = CW'(NUM_WORDS);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                           state_q, state_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [CW-1:0]                    len_q, len_d;
  logic [NUM_WORDS-1:0][WIDTH-1:0]  buffer;

  logic          in_fire;
  logic          out_fire;
  logic          load;
  logic [CW-1:0] eff_len;

  // Out-of-range lengths (0 or above NUM_WORDS) mean a full vector.
  always_comb begin
    eff_len = in_len;
    if (in_len == '0 || in_len > LEN_MAX)
      eff_len = LEN_MAX;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    load      = 1'b0;

    out_valid = (state_q == SEND);
    out_data  = out_valid ? buffer[idx_q] : '0;
    out_last  = out_valid && (cnt_q == len_q - LEN_ONE);
    out_fire  = out_valid & out_ready;
    in_ready  = (state_q == IDLE) | (out_fire & out_last);
    in_fire   = in_valid & in_ready;

    // An accept in SEND can only coincide with the final beat, so it takes priority.
    if (in_fire) begin
      load    = 1'b1;
      state_d = SEND;
      cnt_d   = '0;
      len_d   = eff_len;
      idx_d   = (REVERSE != 0) ? IW'(eff_len - LEN_ONE) : '0;
    end else if (out_fire) begin
      if (out_last) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + LEN_ONE;
        idx_d = (REVERSE != 0) ? idx_q - IDX_ONE : idx_q + IDX_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Word storage carries no reset; it is only observed while in SEND.
  always_ff @(posedge clk) begin
    if (load)
      buffer <= in_data;
  end

endmodule

// File: tb/tb_word_serializer.sv
// Randomised and directed bench for word_serializer: forward and reverse
// instances share stimulus and are checked against a queue-of-beats model.
module tb_word_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = '0;
  logic [2:0]  in_len = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_f, out_valid_f, out_last_f;
  logic [15:0] out_data_f;
  logic        in_ready_r, out_valid_r, out_last_r;
  logic [15:0] out_data_r;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Each entry is {last, data}; the queue holds the remaining beats in order.
  logic [16:0] qf[$];
  logic [16:0] qr[$];

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(16), .NUM_WORDS(4), .REVERSE(0)) u_fwd (
    .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len),
    .in_valid(in_valid), .in_ready(in_ready_f), .out_data(out_data_f),
    .out_valid(out_valid_f), .out_last(out_last_f), .out_ready(out_ready)
  );

  word_serializer #(.WIDTH(16), .NUM_WORDS(4), .REVERSE(1)) u_rev (
    .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len),
    .in_valid(in_valid), .in_ready(in_ready_r), .out_data(out_data_r),
    .out_valid(out_valid_r), .out_last(out_last_r), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_beats(input logic [63:0] d, input logic [2:0] ln);
    int unsigned L = (ln == 3'd0 || ln > 3'd4) ? 4 : int'(ln);
    for (int unsigned i = 0; i < L; i++) begin
      qf.push_back({i == L - 1, d[i*16 +: 16]});
      qr.push_back({i == L - 1, d[(L-1-i)*16 +: 16]});
    end
  endtask

  task automatic check_outputs(input logic ordy);
    logic exp_rdy;
    exp_rdy = (qf.size() == 0) || (ordy && qf.size() == 1);
    check("fwd_valid", out_valid_f, qf.size() != 0);
    check("rev_valid", out_valid_r, qr.size() != 0);
    check("fwd_ready", in_ready_f, exp_rdy);
    check("rev_ready", in_ready_r, exp_rdy);
    if (qf.size() != 0) begin
      check("fwd_data", out_data_f, qf[0][15:0]);
      check("fwd_last", out_last_f, qf[0][16]);
    end else begin
      check("fwd_idle_data", out_data_f, 0);
      check("fwd_idle_last", out_last_f, 0);
    end
    if (qr.size() != 0) begin
      check("rev_data", out_data_r, qr[0][15:0]);
      check("rev_last", out_last_r, qr[0][16]);
    end else begin
      check("rev_idle_data", out_data_r, 0);
      check("rev_idle_last", out_last_r, 0);
    end
  endtask

  // One clock: drive at negedge, check #1 later, then advance the model.
  task automatic step(input logic iv, input logic [63:0] d, input logic [2:0] ln,
                      input logic ordy, output logic fired);
    logic exp_rdy;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_len    = ln;
    out_ready = ordy;
    #1;
    check_outputs(ordy);
    exp_rdy = (qf.size() == 0) || (ordy && qf.size() == 1);
    fired = iv && exp_rdy;
    if (ordy && qf.size() != 0) void'(qf.pop_front());
    if (ordy && qr.size() != 0) void'(qr.pop_front());
    if (fired) push_beats(d, ln);
  endtask

  task automatic drain();
    logic f;
    for (int unsigned k = 0; k < 20 && (qf.size() != 0 || qr.size() != 0); k++)
      step(1'b0, '0, 3'd0, 1'b1, f);
    step(1'b0, '0, 3'd0, 1'b1, f);
    check("drain_fwd", qf.size(), 0);
    check("drain_rev", qr.size(), 0);
  endtask

  localparam logic [63:0] V1234 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] VA    = 64'h00A3_00A2_00A1_00A0;
  localparam logic [63:0] VB    = 64'h00B3_00B2_00B1_00B0;

  initial begin
    logic f;
    logic got;
    repeat (2) @(negedge clk);
    #1;
    check_outputs(1'b0);
    rst = 1'b0;

    // Full-length vector, then length 3.
    step(1'b1, V1234, 3'd4, 1'b1, f);
    check("basic_accept", f, 1);
    drain();
    step(1'b1, V1234, 3'd3, 1'b1, f);
    drain();

    // Backpressure while the second word is presented.
    step(1'b1, V1234, 3'd4, 1'b1, f);
    step(1'b0, '0, 3'd0, 1'b1, f);
    repeat (5) step(1'b1, VA, 3'd4, 1'b0, f);
    drain();

    // Back-to-back: A accepted from idle, B held valid until accepted.
    step(1'b1, VA, 3'd4, 1'b1, f);
    got = 1'b0;
    for (int unsigned k = 0; k < 10 && !got; k++) begin
      step(1'b1, VB, 3'd4, 1'b1, f);
      got = f;
    end
    check("b2b_accept_B", got, 1);
    drain();

    // Length edge cases.
    step(1'b1, V1234, 3'd0, 1'b1, f);
    drain();
    step(1'b1, 64'h0000_0000_0000_BEEF, 3'd1, 1'b1, f);
    drain();
    step(1'b1, V1234, 3'd7, 1'b1, f);
    drain();

    // Asynchronous reset after the second output word.
    step(1'b1, V1234, 3'd4, 1'b1, f);
    step(1'b0, '0, 3'd0, 1'b1, f);
    step(1'b0, '0, 3'd0, 1'b1, f);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    qf.delete();
    qr.delete();
    check_outputs(1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(1'b0, '0, 3'd0, 1'b1, f);
    step(1'b1, VB, 3'd4, 1'b1, f);
    drain();

    // Randomised traffic.
    for (int unsigned k = 0; k < 600; k++) begin
      step($urandom_range(0, 1) == 1,
           {$urandom(), $urandom()},
           3'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, f);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
